// File: rtl/flash_bist_if.sv
// Command/data bundle between the BIST sequencer and flash_ctrl.
// master = sequencer side, slave = flash controller side.
interface flash_bist_if;
    logic [3:0]  cmd_type;
    logic        cmd_req;
    logic        cmd_ack;
    logic        flash_is_busy;
    logic [31:0] total_bytes;
    logic [7:0]  wr_data;
    logic        wr_data_pop;
    logic        wr_flash_done;
    logic        erase_flash_done;
    logic [7:0]  rd_data;
    logic        rd_data_valid;
    logic        rd_flash_done;

    modport master (
        output cmd_type, cmd_req, total_bytes, wr_data,
        input  cmd_ack, flash_is_busy, wr_data_pop, wr_flash_done,
        input  erase_flash_done, rd_data, rd_data_valid, rd_flash_done
    );

    modport slave (
        input  cmd_type, cmd_req, total_bytes, wr_data,
        output cmd_ack, flash_is_busy, wr_data_pop, wr_flash_done,
        output erase_flash_done, rd_data, rd_data_valid, rd_flash_done
    );
endinterface

// File: rtl/flash_bist_seq.sv
// Flash BIST sequencer: erase -> blank-check -> program -> verify,
// repeated for a number of passes, with error count and first error offset.
module flash_bist_seq #(
    parameter logic [31:0] REGION_BYTES = 32'h0002_0000,
    parameter logic [3:0]  CMD_WR       = 4'd3,
    parameter logic [3:0]  CMD_ERASE    = 4'd4,
    parameter logic [3:0]  CMD_RD       = 4'd5,
    parameter int          LOOP_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [7:0]        seed,
    input  logic [LOOP_W-1:0] loops,
    flash_bist_if.master      fl,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LOOP_W-1:0] pass_cnt,
    output logic [31:0]       err_cnt,
    output logic [31:0]       first_err_addr,
    output logic              error_flag
);
    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] ER_REQ  = 4'd1;
    localparam logic [3:0] ER_WAIT = 4'd2;
    localparam logic [3:0] BC_REQ  = 4'd3;
    localparam logic [3:0] BC_WAIT = 4'd4;
    localparam logic [3:0] WR_REQ  = 4'd5;
    localparam logic [3:0] WR_WAIT = 4'd6;
    localparam logic [3:0] RD_REQ  = 4'd7;
    localparam logic [3:0] RD_WAIT = 4'd8;
    localparam logic [3:0] DONE    = 4'd9;

    logic [3:0]        state;
    logic [1:0]        mode_q;
    logic [7:0]        seed_q;
    logic [LOOP_W-1:0] loops_q;
    logic [31:0]       idx;
    logic [7:0]        lfsr;
    logic              abort_pend;
    logic              cmd_req_q;
    logic [3:0]        cmd_type_q;

    logic [7:0]        s_eff;
    logic [7:0]        pat;
    logic [7:0]        lfsr_nxt;
    logic [7:0]        exp_byte;
    logic              is_req;
    logic              is_rd;
    logic              rd_v;
    logic              rd_fin;
    logic              wr_pop;
    logic              byte_err;
    logic [31:0]       idx_n;
    logic [31:0]       under;
    logic [33:0]       err_sum;
    logic [31:0]       err_nxt;
    logic [3:0]        req_code;
    logic [3:0]        wait_st;
    logic [3:0]        nxt_st;
    logic              wait_done;
    logic [LOOP_W-1:0] pass_inc;

    assign s_eff    = seed_q + pass_cnt[7:0];
    assign lfsr_nxt = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
    assign pass_inc = pass_cnt + 1'b1;

    always_comb begin
        unique case (mode_q)
            2'd1:    pat = lfsr;
            2'd2:    pat = s_eff;
            default: pat = s_eff + idx[7:0];
        endcase
    end

    assign fl.wr_data     = (state == WR_WAIT) ? pat : 8'h00;
    assign fl.total_bytes = REGION_BYTES;
    assign fl.cmd_req     = cmd_req_q;
    assign fl.cmd_type    = cmd_type_q;

    // Blank-check expects erased flash; verify expects the program pattern
    assign is_rd    = (state == BC_WAIT) || (state == RD_WAIT);
    assign exp_byte = (state == BC_WAIT) ? 8'hFF : pat;
    assign rd_v     = is_rd && fl.rd_data_valid;
    assign rd_fin   = is_rd && fl.rd_flash_done;
    assign wr_pop   = (state == WR_WAIT) && fl.wr_data_pop;
    assign byte_err = rd_v && ((idx >= REGION_BYTES) || (fl.rd_data != exp_byte));
    assign idx_n    = idx + {31'd0, rd_v};
    assign under    = (rd_fin && (idx_n < REGION_BYTES)) ? (REGION_BYTES - idx_n) : 32'd0;
    assign err_sum  = {2'b00, err_cnt} + {33'd0, byte_err} + {2'b00, under};
    assign err_nxt  = (err_sum[33:32] != 2'b00) ? 32'hFFFF_FFFF : err_sum[31:0];

    always_comb begin
        is_req    = 1'b1;
        req_code  = 4'd0;
        wait_st   = IDLE;
        wait_done = 1'b0;
        nxt_st    = IDLE;
        unique case (state)
            ER_REQ:  begin req_code = CMD_ERASE; wait_st = ER_WAIT; end
            BC_REQ:  begin req_code = CMD_RD;    wait_st = BC_WAIT; end
            WR_REQ:  begin req_code = CMD_WR;    wait_st = WR_WAIT; end
            RD_REQ:  begin req_code = CMD_RD;    wait_st = RD_WAIT; end
            ER_WAIT: begin is_req = 1'b0; wait_done = fl.erase_flash_done; nxt_st = BC_REQ; end
            BC_WAIT: begin is_req = 1'b0; wait_done = fl.rd_flash_done;    nxt_st = WR_REQ; end
            WR_WAIT: begin is_req = 1'b0; wait_done = fl.wr_flash_done;    nxt_st = RD_REQ; end
            RD_WAIT: begin is_req = 1'b0; wait_done = fl.rd_flash_done;    nxt_st = ER_REQ; end
            default: is_req = 1'b0;
        endcase
    end

    assign error_flag = (err_cnt != 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            mode_q         <= 2'd0;
            seed_q         <= 8'd0;
            loops_q        <= '0;
            idx            <= 32'd0;
            lfsr           <= 8'h01;
            abort_pend     <= 1'b0;
            cmd_req_q      <= 1'b0;
            cmd_type_q     <= 4'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            aborted        <= 1'b0;
            pass_cnt       <= '0;
            err_cnt        <= 32'd0;
            first_err_addr <= 32'hFFFF_FFFF;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) abort_pend <= 1'b1;
            if (wr_pop) begin
                idx  <= idx + 32'd1;
                lfsr <= lfsr_nxt;
            end
            if (rd_v) begin
                idx <= idx_n;
                if (state == RD_WAIT) lfsr <= lfsr_nxt;
            end
            // err_cnt still zero means this is the run's first error
            if (rd_v || rd_fin) begin
                err_cnt <= err_nxt;
                if (err_cnt == 32'd0 && (byte_err || under != 32'd0))
                    first_err_addr <= byte_err ? idx : idx_n;
            end
            if (is_req) begin
                idx  <= 32'd0;
                lfsr <= (s_eff == 8'd0) ? 8'h01 : s_eff;
                if (!cmd_req_q) begin
                    if (!fl.flash_is_busy) begin
                        cmd_req_q  <= 1'b1;
                        cmd_type_q <= req_code;
                    end
                end else if (fl.cmd_ack) begin
                    cmd_req_q <= 1'b0;
                    state     <= wait_st;
                end
            end
            if (wait_done) begin
                if (state == RD_WAIT) pass_cnt <= pass_inc;
                if (abort_pend || abort) begin
                    state      <= DONE;
                    aborted    <= 1'b1;
                    abort_pend <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                end else if (state == RD_WAIT && loops_q != '0 && pass_inc == loops_q) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state <= nxt_st;
                end
            end
            if (state == DONE) state <= IDLE;
            if (state == IDLE && start) begin
                mode_q         <= mode;
                seed_q         <= seed;
                loops_q        <= loops;
                pass_cnt       <= '0;
                err_cnt        <= 32'd0;
                first_err_addr <= 32'hFFFF_FFFF;
                aborted        <= 1'b0;
                abort_pend     <= 1'b0;
                busy           <= 1'b1;
                state          <= ER_REQ;
            end
        end
    end
endmodule

// File: tb/tb_flash_bist_seq.sv
// Directed bench for flash_bist_seq with a behavioural flash_ctrl model
// and queue scoreboards for program bytes and end-of-run status.
module tb_flash_bist_seq;
    localparam logic [31:0] NB = 32'd16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  seed = 8'd0;
    logic [15:0] loops = 16'd0;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        error_flag;
    logic [15:0] pass_cnt;
    logic [31:0] err_cnt;
    logic [31:0] first_err_addr;

    flash_bist_if fl();

    flash_bist_seq #(.REGION_BYTES(NB)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .mode(mode), .seed(seed), .loops(loops), .fl(fl),
        .busy(busy), .done(done), .aborted(aborted),
        .pass_cnt(pass_cnt), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr), .error_flag(error_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] ec;
        logic [31:0] fa;
        logic        ab;
    } stat_t;

    stat_t      exp_st[$];
    logic [7:0] exp_wr[$];

    int tests = 0;
    int fails = 0;

    int          ack_dly = 0;
    int          busy_hold = 2;
    int          cor_idx = -1;
    int          trunc = 0;
    logic [15:0] bc_zero = 16'h0000;
    logic [7:0]  cor_val = 8'h00;
    int          cmd_n = 0;
    int          rd_n = 0;
    int          cmd_base = 0;
    int          rd_base = 0;
    bit          in_write = 1'b0;

    int   viol = 0;
    int   done_cnt = 0;
    int   req_len = 0;
    int   last_len = 0;
    logic p_req = 1'b0;
    logic p_busy = 1'b0;
    logic p_ack = 1'b0;
    logic p_rst = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[0], l[7], l[6] ^ l[0], l[5] ^ l[0], l[4] ^ l[0], l[3], l[2], l[1]};
    endfunction

    function automatic logic [3:0] code_of(input int k);
        case (k % 4)
            0:       return 4'd4;
            2:       return 4'd3;
            default: return 4'd5;
        endcase
    endfunction

    task automatic push_pass(input logic [1:0] m, input logic [7:0] sd, input int p);
        logic [7:0] s;
        logic [7:0] l;
        s = sd + p[7:0];
        l = (s == 8'd0) ? 8'h01 : s;
        for (int i = 0; i < 16; i++) begin
            if (m == 2'd1) exp_wr.push_back(l);
            else if (m == 2'd2) exp_wr.push_back(s);
            else exp_wr.push_back(s + i[7:0]);
            l = lfsr_step(l);
        end
    endtask

    // Protocol monitor: request only when idle flash, drop only after ack
    always @(negedge clk) begin
        if (!rst && !p_rst) begin
            if (fl.cmd_req && !p_req && p_busy) viol++;
            if (!fl.cmd_req && p_req && !p_ack) viol++;
        end
        if (fl.cmd_req) req_len++;
        else if (p_req) begin
            last_len = req_len;
            req_len = 0;
        end
        if (done === 1'b1) done_cnt++;
        p_req  = fl.cmd_req;
        p_busy = fl.flash_is_busy;
        p_ack  = fl.cmd_ack;
        p_rst  = rst;
    end

    initial begin : flash_model
        logic [7:0] mem [16];
        logic [3:0] ct;
        logic [7:0] b;
        logic [7:0] e;
        int         len;
        int         rel;
        bit         bc;
        fl.cmd_ack = 1'b0;
        fl.flash_is_busy = 1'b0;
        fl.wr_data_pop = 1'b0;
        fl.wr_flash_done = 1'b0;
        fl.erase_flash_done = 1'b0;
        fl.rd_data = 8'h00;
        fl.rd_data_valid = 1'b0;
        fl.rd_flash_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (fl.cmd_req === 1'b1) begin
                for (int i = 0; i < ack_dly; i++) begin @(posedge clk); #1; end
                ct = fl.cmd_type;
                if (fl.cmd_req === 1'b1)
                    chk("cmd_type", {28'd0, ct}, {28'd0, code_of(cmd_n - cmd_base)});
                cmd_n++;
                fl.cmd_ack = 1'b1;
                fl.flash_is_busy = 1'b1;
                @(posedge clk); #1;
                fl.cmd_ack = 1'b0;
                if (ct == 4'd4) begin
                    repeat (2) begin @(posedge clk); #1; end
                    for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
                    fl.erase_flash_done = 1'b1;
                    @(posedge clk); #1;
                    fl.erase_flash_done = 1'b0;
                end else if (ct == 4'd3) begin
                    in_write = 1'b1;
                    for (int i = 0; i < 16; i++) begin
                        fl.wr_data_pop = 1'b1;
                        if (exp_wr.size() > 0) e = exp_wr.pop_front();
                        else e = ~fl.wr_data;
                        chk("wr_data", {24'd0, fl.wr_data}, {24'd0, e});
                        mem[i] = fl.wr_data;
                        @(posedge clk); #1;
                    end
                    fl.wr_data_pop = 1'b0;
                    in_write = 1'b0;
                    fl.wr_flash_done = 1'b1;
                    @(posedge clk); #1;
                    fl.wr_flash_done = 1'b0;
                end else if (ct == 4'd5) begin
                    rel = rd_n - rd_base;
                    rd_n++;
                    bc  = (rel % 2 == 0);
                    len = (!bc && rel == 1 && trunc != 0) ? trunc : 16;
                    for (int i = 0; i < len; i++) begin
                        b = mem[i];
                        if (bc && rel == 0 && bc_zero[i]) b = 8'h00;
                        if (!bc && rel == 1 && i == cor_idx) b = cor_val;
                        fl.rd_data = b;
                        fl.rd_data_valid = 1'b1;
                        fl.rd_flash_done = (i == len - 1);
                        @(posedge clk); #1;
                    end
                    fl.rd_data_valid = 1'b0;
                    fl.rd_flash_done = 1'b0;
                end
                for (int i = 0; i < busy_hold; i++) begin @(posedge clk); #1; end
                fl.flash_is_busy = 1'b0;
            end
        end
    end

    int done_base = 0;

    task automatic start_run(input logic [1:0] m, input logic [7:0] sd,
                             input logic [15:0] lp, input stat_t st);
        mode = m;
        seed = sd;
        loops = lp;
        exp_st.push_back(st);
        cmd_base = cmd_n;
        rd_base = rd_n;
        done_base = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic finish_run(input string tag);
        int    c;
        stat_t st;
        c = 0;
        while (done !== 1'b1 && c < 4000) begin
            @(posedge clk); #1;
            c++;
        end
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        st = exp_st.pop_front();
        chk({tag, ".pass_cnt"}, {16'd0, pass_cnt}, {16'd0, st.pc});
        chk({tag, ".err_cnt"}, err_cnt, st.ec);
        chk({tag, ".first_err"}, first_err_addr, st.fa);
        chk({tag, ".aborted"}, {31'd0, aborted}, {31'd0, st.ab});
        chk({tag, ".error_flag"}, {31'd0, error_flag}, {31'd0, (st.ec != 32'd0)});
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk({tag, ".done_pulses"}, done_cnt - done_base, 32'd1);
        chk({tag, ".wr_left"}, exp_wr.size(), 32'd0);
        chk({tag, ".protocol"}, viol, 32'd0);
    endtask

    initial begin : main
        int c;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.cmd_req", {31'd0, fl.cmd_req}, 32'd0);
        chk("rst.cmd_type", {28'd0, fl.cmd_type}, 32'd0);
        chk("rst.err_cnt", err_cnt, 32'd0);
        chk("rst.first_err", first_err_addr, 32'hFFFF_FFFF);
        chk("rst.pass_cnt", {16'd0, pass_cnt}, 32'd0);
        chk("rst.wr_data", {24'd0, fl.wr_data}, 32'd0);
        chk("total_bytes", fl.total_bytes, NB);
        rst = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("idle_abort.busy", {31'd0, busy}, 32'd0);

        // increment pattern, one pass, with an ignored mid-run start
        push_pass(2'd0, 8'h10, 0);
        start_run(2'd0, 8'h10, 16'd1, '{16'd1, 32'd0, 32'hFFFF_FFFF, 1'b0});
        repeat (30) @(posedge clk);
        #1;
        mode = 2'd1;
        seed = 8'h77;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        finish_run("inc");

        // LFSR pattern over two passes
        push_pass(2'd1, 8'h00, 0);
        push_pass(2'd1, 8'h00, 1);
        start_run(2'd1, 8'h00, 16'd2, '{16'd2, 32'd0, 32'hFFFF_FFFF, 1'b0});
        finish_run("lfsr");

        // constant pattern, one corrupted verify byte
        cor_idx = 5;
        cor_val = 8'hA4;
        push_pass(2'd2, 8'hA5, 0);
        start_run(2'd2, 8'hA5, 16'd1, '{16'd1, 32'd1, 32'd5, 1'b0});
        finish_run("const_corrupt");
        cor_idx = -1;

        // blank-check returns zero at two offsets
        bc_zero = 16'h0208;
        push_pass(2'd0, 8'h00, 0);
        start_run(2'd0, 8'h00, 16'd1, '{16'd1, 32'd2, 32'd3, 1'b0});
        finish_run("blank");
        bc_zero = 16'h0000;

        // verify read underrun, done coincident with the last byte
        trunc = 12;
        push_pass(2'd0, 8'h33, 0);
        start_run(2'd0, 8'h33, 16'd1, '{16'd1, 32'd4, 32'd12, 1'b0});
        finish_run("underrun");
        trunc = 0;

        // endless run aborted during program, slow ack and busy tail
        ack_dly = 5;
        busy_hold = 3;
        push_pass(2'd0, 8'h40, 0);
        start_run(2'd0, 8'h40, 16'd0, '{16'd0, 32'd0, 32'hFFFF_FFFF, 1'b1});
        c = 0;
        while (!in_write && c < 2000) begin
            @(posedge clk); #1;
            c++;
        end
        chk("abort.reached_write", {31'd0, in_write}, 32'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        finish_run("abort");
        chk("abort.req_hold", last_len, 32'd6);
        chk("abort.cmd_count", cmd_n - cmd_base, 32'd3);

        // reset in the middle of a request
        mode = 2'd0;
        seed = 8'h00;
        loops = 16'd1;
        cmd_base = cmd_n;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst.req_before", {31'd0, fl.cmd_req}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst.busy", {31'd0, busy}, 32'd0);
        chk("midrst.cmd_req", {31'd0, fl.cmd_req}, 32'd0);
        chk("midrst.aborted", {31'd0, aborted}, 32'd0);
        chk("midrst.first_err", first_err_addr, 32'hFFFF_FFFF);
        repeat (30) @(posedge clk);
        #1;
        chk("midrst.stays_idle", {31'd0, busy}, 32'd0);
        chk("final.protocol", viol, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/flash_bist_seq.md
Name: flash_bist_seq

Overview:
- Autonomous built-in self-test sequencer for the QSPI flash controller (flash_ctrl).
- Replaces manual VIO-triggered commands with a parametrised loop: erase region -> blank-check read -> pattern program -> pattern verify read, repeated N passes.
- Selectable data pattern; reports error count, first failing byte offset and pass count; drives flash_ctrl through its cmd_req/cmd_ack handshake.

Parameters:
- REGION_BYTES, 32'h0002_0000, bytes covered by every erase/program/read command (>=1).
- CMD_WR, 4'd3, flash_ctrl command code for page-program.
- CMD_ERASE, 4'd4, flash_ctrl command code for erase.
- CMD_RD, 4'd5, flash_ctrl command code for data read.
- LOOP_W, 16, width of loops and pass_cnt.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle pulse; begins a run when idle.
- abort  in  1  single-cycle pulse; requests stop after the current flash command.
- mode  in  2  pattern: 0 = increment, 1 = LFSR, 2 = constant, 3 = reserved (treated as 0).
- seed  in  8  pattern seed, sampled on start.
- loops  in  LOOP_W  passes to run, sampled on start; 0 = run until abort.
- cmd_type  out  4  command to flash_ctrl.
- cmd_req  out  1  command request.
- cmd_ack  in  1  command accepted.
- flash_is_busy  in  1  controller busy.
- total_bytes  out  32  constant REGION_BYTES.
- wr_data  out  8  program byte; valid when wr_data_pop is high.
- wr_data_pop  in  1  controller consumes wr_data this cycle.
- wr_flash_done  in  1  program complete pulse.
- erase_flash_done  in  1  erase complete pulse.
- rd_data  in  8  read byte.
- rd_data_valid  in  1  rd_data valid.
- rd_flash_done  in  1  read complete pulse.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at end of run.
- aborted  out  1  run ended by abort; held until next start.
- pass_cnt  out  LOOP_W  completed passes.
- err_cnt  out  32  mismatching or missing bytes, saturating at 32'hFFFF_FFFF.
- first_err_addr  out  32  byte offset of first error in run; 32'hFFFF_FFFF if none.
- error_flag  out  1  err_cnt != 0.

Behaviour:
- Reset: state IDLE; cmd_req=0, cmd_type=0, busy=0, done=0, aborted=0, pass_cnt=0, err_cnt=0, first_err_addr=32'hFFFF_FFFF, error_flag=0, wr_data=0.
- States: IDLE, ER_REQ, ER_WAIT, BC_REQ, BC_WAIT, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE.
- IDLE: on start, latch mode/seed/loops, clear status registers and aborted, go to ER_REQ. start in any other state is ignored.
- X_REQ: assert cmd_req and set cmd_type once flash_is_busy=0. Hold both until cmd_ack is sampled high; drop cmd_req the next cycle and enter X_WAIT. BC uses CMD_RD.
- ER_WAIT exits on erase_flash_done; BC_WAIT and RD_WAIT exit on rd_flash_done; WR_WAIT exits on wr_flash_done. Done pulses arriving in any other state are ignored.
- Sequence: ER -> BC -> WR -> RD. At RD exit, pass_cnt += 1. If abort is pending, or loops != 0 and the new pass_cnt == loops, go to DONE; otherwise go to ER_REQ.
- abort: sets a pending flag in any busy state. It takes effect at the next X_WAIT exit: go to DONE and set aborted=1. abort in IDLE is ignored.
- DONE: done=1 for one cycle, busy=0, return to IDLE. Status holds until the next start.
- Byte index: 32-bit counter, cleared on entry to every REQ state. It increments on wr_data_pop in WR_WAIT and on rd_data_valid in BC_WAIT/RD_WAIT.
- Pattern, with effective seed s = seed + pass_cnt[7:0] (mod 256):
  - Increment: s + idx[7:0].
  - Constant: s.
  - LFSR: Galois x^8+x^6+x^5+x^4+1. Loaded with s (s=0 -> 8'h01) on REQ entry; advances one step per pop/valid, after use.
- wr_data presents the current pattern byte combinationally from registered state. Same-cycle pop advances to the next byte.
- Checking: BC expects 8'hFF; RD expects the same pattern sequence as WR.
  - Mismatch with valid: err_cnt += 1.
  - Valid with idx >= REGION_BYTES (overrun): counted as an error.
  - rd_flash_done with idx < REGION_BYTES (underrun): adds REGION_BYTES - idx (saturating).
  - first_err_addr captures idx of the first error of the run. For underrun it is the first missing offset.
- Simultaneous rd_data_valid and rd_flash_done: the byte is checked first, then the underrun check uses the updated idx.
- rst mid-run returns to reset values immediately; the flash controller is reset by its own rst.

Test Plan:
- REGION_BYTES=16, mode=0, seed=8'h10, loops=1, ideal flash model -> programmed bytes 8'h10..8'h1F; done after one pass; pass_cnt=1, err_cnt=0, first_err_addr=32'hFFFF_FFFF.
- mode=1, seed=0, loops=2 -> pass 0 LFSR starts 8'h01, pass 1 starts 8'h01 (s=1); read data matches; pass_cnt=2, error_flag=0.
- Model corrupts read byte 5 of pass 0 (mode=2, seed=8'hA5, returns 8'hA4) -> err_cnt=1, first_err_addr=5, run continues to completion.
- Blank-check returns 8'h00 at offsets 3 and 9 -> err_cnt=2, first_err_addr=3.
- Read ends after 12 of 16 bytes -> err_cnt=4, first_err_addr=12.
- loops=0 with abort pulsed during WR_WAIT; cmd_ack delayed 5 cycles with flash_is_busy=1 for 3 -> cmd_req held until ack; run stops after wr_flash_done; aborted=1; done pulses once; pass_cnt unchanged.
